sseg_scan_driver: RTL and testbench

- Parametrised, tick-driven multiplexed seven-segment display driver. It is the successor to the fixed 4-digit decoder.
- Scans NUM_DIGITS digits and decodes packed BCD, with:
  - leading-zero blanking
  - per-digit decimal points
  - overflow and invalid-code handling
  - idle/test/off modes
  - frame-coherent input capture
- Sits between the system FSM/BCD converter and the board display pins.

---
 rtl/sseg_scan_driver.sv | 166 ++++++++++++++++
 tb/tb_sseg_scan_driver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// Tick-driven multiplexed seven-segment driver: scans NUM_DIGITS digits from a
// frame-coherent snapshot of mode/BCD/dp, with blanking, overflow and test modes.
module sseg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tic_ms,
    input  logic [1:0]              mode,
    input  logic [4*NUM_DIGITS-1:0] bcd,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank_lz,
    output logic [7:0]              sseg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [7:0] SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'b00,
        MODE_NUMBER = 2'b01,
        MODE_TEST   = 2'b10,
        MODE_OFF    = 2'b11
    } mode_e;

    logic [IW-1:0]           idx_q, idx_d;
    mode_e                   mode_q, mode_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic                    blz_q, blz_d;
    logic                    tic_q;
    logic [7:0]              sseg_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    fd_q;

    function automatic logic [7:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    glyph = 8'hC0;
            4'd1:    glyph = 8'hF9;
            4'd2:    glyph = 8'hA4;
            4'd3:    glyph = 8'hB0;
            4'd4:    glyph = 8'h99;
            4'd5:    glyph = 8'h92;
            4'd6:    glyph = 8'h82;
            4'd7:    glyph = 8'hF8;
            4'd8:    glyph = 8'h80;
            4'd9:    glyph = 8'h98;
            default: glyph = 8'hBF;
        endcase
    endfunction

    // Snapshot registers load only on the wrapping tick, so a frame never mixes inputs.
    always_comb begin
        idx_d  = idx_q;
        mode_d = mode_q;
        bcd_d  = bcd_q;
        dp_d   = dp_q;
        blz_d  = blz_q;
        if (tic_ms) begin
            if (idx_q == LAST_IDX) begin
                idx_d  = '0;
                mode_d = mode_e'(mode);
                bcd_d  = bcd;
                dp_d   = dp;
                blz_d  = blank_lz;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  upper_nz;
    logic [NUM_DIGITS-1:0] one_hot;
    logic [7:0]            seg_lo;
    logic [NUM_DIGITS-1:0] an_hi;

    always_comb begin
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        upper_nz = 1'b0;
        one_hot  = '0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (IW'(j) == idx_q) begin
                cur_nib    = bcd_q[4*j +: 4];
                cur_dp     = dp_q[j];
                one_hot[j] = 1'b1;
            end
            if (IW'(j) >= idx_q && bcd_q[4*j +: 4] != 4'h0) upper_nz = 1'b1;
        end
    end

    // Display decode is done in active-low terms; polarity is applied at the register.
    always_comb begin
        seg_lo = 8'hFF;
        an_hi  = '0;
        case (mode_q)
            MODE_IDLE: begin
                if (idx_q == '0) begin
                    an_hi  = one_hot;
                    seg_lo = 8'hCF;
                end else if (idx_q == IW'(1)) begin
                    an_hi  = one_hot;
                    seg_lo = 8'h89;
                end
            end
            MODE_NUMBER: begin
                an_hi = one_hot;
                if (&bcd_q) begin
                    seg_lo = 8'h98;
                end else if (cur_nib > 4'd9) begin
                    seg_lo = 8'hBF;
                end else if (blz_q && idx_q != '0 && !upper_nz) begin
                    an_hi  = '0;
                    seg_lo = 8'hFF;
                end else begin
                    seg_lo = glyph(cur_nib);
                end
                if (an_hi != '0 && cur_dp) seg_lo[7] = 1'b0;
            end
            MODE_TEST: begin
                an_hi  = one_hot;
                seg_lo = 8'h00;
            end
            default: begin
                an_hi  = '0;
                seg_lo = 8'hFF;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= LAST_IDX;
            mode_q <= MODE_OFF;
            bcd_q  <= '0;
            dp_q   <= '0;
            blz_q  <= 1'b0;
            tic_q  <= 1'b0;
            sseg_q <= SEG_OFF;
            an_q   <= AN_OFF;
            fd_q   <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            mode_q <= mode_d;
            bcd_q  <= bcd_d;
            dp_q   <= dp_d;
            blz_q  <= blz_d;
            tic_q  <= tic_ms;
            sseg_q <= ACTIVE_LOW ? seg_lo : ~seg_lo;
            an_q   <= ACTIVE_LOW ? ~an_hi : an_hi;
            fd_q   <= tic_q && (idx_q == '0);
        end
    end

    assign sseg       = sseg_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver (4 digits, active-low): table vectors, corner
// sequences and randomized frames against an arithmetic reference model.
module tb_sseg_scan_driver;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         tic_ms;
    logic [1:0]   mode;
    logic [15:0]  bcd;
    logic [3:0]   dp;
    logic         blank_lz;
    logic [7:0]   sseg;
    logic [3:0]   an;
    logic         frame_done;

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q[$];

    // reference model state: scan position plus the latched frame inputs
    int         m_idx;
    logic [1:0] m_mode;
    logic [15:0] m_bcd;
    logic [3:0] m_dp;
    logic       m_blz;

    logic [7:0] glyph_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                    8'h92, 8'h82, 8'hF8, 8'h80, 8'h98};

    typedef struct packed {
        logic [1:0]  mode;
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        blz;
        logic [15:0] an4;
        logic [31:0] seg4;
    } vec_t;

    vec_t vecs [10];

    sseg_scan_driver #(.NUM_DIGITS(N), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .tic_ms(tic_ms), .mode(mode), .bcd(bcd),
        .dp(dp), .blank_lz(blank_lz), .sseg(sseg), .an(an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // {an, sseg} for one digit position, computed straight from the display rules
    function automatic logic [11:0] ref_out(int idx, logic [1:0] md, logic [15:0] b,
                                            logic [3:0] d, logic z);
        logic [3:0]  a;
        logic [7:0]  s;
        logic [3:0]  nib;
        logic [15:0] upper;
        a     = 4'hF ^ (4'd1 << idx);
        nib   = 4'((b >> (4 * idx)) & 16'hF);
        upper = b >> (4 * idx);
        case (md)
            2'b00: begin
                if (idx == 0)      s = 8'hCF;
                else if (idx == 1) s = 8'h89;
                else begin a = 4'hF; s = 8'hFF; end
            end
            2'b01: begin
                if (b == 16'hFFFF)               s = 8'h98;
                else if (nib > 9)                s = 8'hBF;
                else if (z && idx != 0 && upper == 0) begin a = 4'hF; s = 8'hFF; end
                else                             s = glyph_tab[nib];
                if (a != 4'hF && d[idx]) s = s & 8'h7F;
            end
            2'b10:   s = 8'h00;
            default: begin a = 4'hF; s = 8'hFF; end
        endcase
        return {a, s};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tic_ms = 1'b0;
        m_idx = N - 1; m_mode = 2'b11; m_bcd = '0; m_dp = '0; m_blz = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // one scan step: pulse tic_ms, let the output register update, then compare
    task automatic tic_step(output logic [12:0] act);
        logic [12:0] exp;
        @(negedge clk);
        tic_ms = 1'b1;
        m_idx = (m_idx + 1) % N;
        if (m_idx == 0) begin
            m_mode = mode; m_bcd = bcd; m_dp = dp; m_blz = blank_lz;
        end
        exp_q.push_back({m_idx == 0, ref_out(m_idx, m_mode, m_bcd, m_dp, m_blz)});
        @(negedge clk);
        tic_ms = 1'b0;
        @(negedge clk);
        act = {frame_done, an, sseg};
        exp = exp_q.pop_front();
        check("model_step", act, exp);
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        int kind;
        kind = $urandom_range(0, 9);
        v = '0;
        if (kind == 0) v = 16'hFFFF;
        else begin
            for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'($urandom_range(0, 11));
            if (kind <= 3) v = v >> (4 * $urandom_range(1, 4));
        end
        return v;
    endfunction

    initial begin
        logic [12:0] act;
        logic [11:0] hold_exp;

        vecs[0] = '{2'b01, 16'h0123, 4'h0, 1'b0, 16'h7BDE, 32'hC0F9A4B0};
        vecs[1] = '{2'b01, 16'h0045, 4'h2, 1'b1, 16'hFFDE, 32'hFFFF1992};
        vecs[2] = '{2'b01, 16'h0000, 4'h2, 1'b1, 16'hFFFE, 32'hFFFFFFC0};
        vecs[3] = '{2'b01, 16'hFFFF, 4'h0, 1'b0, 16'h7BDE, 32'h98989898};
        vecs[4] = '{2'b01, 16'h0A07, 4'h0, 1'b0, 16'h7BDE, 32'hC0BFC0F8};
        vecs[5] = '{2'b00, 16'h1234, 4'hF, 1'b0, 16'hFFDE, 32'hFFFF89CF};
        vecs[6] = '{2'b10, 16'h0000, 4'h0, 1'b1, 16'h7BDE, 32'h00000000};
        vecs[7] = '{2'b11, 16'h5678, 4'hF, 1'b0, 16'hFFFF, 32'hFFFFFFFF};
        vecs[8] = '{2'b01, 16'hFFFF, 4'hF, 1'b1, 16'h7BDE, 32'h18181818};
        vecs[9] = '{2'b01, 16'h0900, 4'h8, 1'b1, 16'hFBDE, 32'hFF98C0C0};

        rst = 1'b1; tic_ms = 1'b0; mode = 2'b01; bcd = 16'h0123; dp = '0; blank_lz = 1'b0;
        do_reset();
        check("reset_state", {frame_done, an, sseg}, {1'b0, 4'hF, 8'hFF});
        repeat (5) @(negedge clk);
        check("no_tic_hold", {frame_done, an, sseg}, {1'b0, 4'hF, 8'hFF});

        foreach (vecs[v]) begin
            mode = vecs[v].mode; bcd = vecs[v].bcd; dp = vecs[v].dp; blank_lz = vecs[v].blz;
            for (int d = 0; d < N; d++) begin
                tic_step(act);
                check($sformatf("vec%0d_digit%0d", v, d), {20'h0, act[11:0]},
                      {20'h0, vecs[v].an4[4*d +: 4], vecs[v].seg4[8*d +: 8]});
                check($sformatf("vec%0d_fd%0d", v, d), {31'h0, act[12]}, {31'h0, d == 0});
            end
        end

        // mode/bcd change mid-frame stays invisible until the next wrap
        mode = 2'b00; bcd = 16'h0000; dp = '0; blank_lz = 1'b0;
        tic_step(act); check("idle_d0", {19'h0, act}, {19'h0, 1'b1, 4'hE, 8'hCF});
        tic_step(act); check("idle_d1", {19'h0, act}, {19'h0, 1'b0, 4'hD, 8'h89});
        mode = 2'b01; bcd = 16'h0123;
        tic_step(act); check("mid_d2", {19'h0, act}, {19'h0, 1'b0, 4'hF, 8'hFF});
        tic_step(act); check("mid_d3", {19'h0, act}, {19'h0, 1'b0, 4'hF, 8'hFF});
        tic_step(act); check("wrap_num", {19'h0, act}, {19'h0, 1'b1, 4'hE, 8'hB0});

        // asynchronous reset in the middle of a frame, away from any clock edge
        tic_step(act);
        tic_step(act);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_rst", {19'h0, frame_done, an, sseg}, {19'h0, 1'b0, 4'hF, 8'hFF});
        m_idx = N - 1; m_mode = 2'b11; m_bcd = '0; m_dp = '0; m_blz = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        tic_step(act); check("post_rst_d0", {19'h0, act}, {19'h0, 1'b1, 4'hE, 8'hB0});
        hold_exp = ref_out(m_idx, m_mode, m_bcd, m_dp, m_blz);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c % 10 == 9)
                check("idle_hold", {19'h0, frame_done, an, sseg}, {19'h0, 1'b0, hold_exp});
        end

        // randomized frames with inputs changing at arbitrary scan positions
        for (int t = 0; t < 240; t++) begin
            if ($urandom_range(0, 9) < 3) begin
                mode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 3) != 0) mode = 2'b01;
                bcd = rand_bcd();
                dp = 4'($urandom_range(0, 15));
                blank_lz = 1'($urandom_range(0, 1));
            end
            tic_step(act);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
